pipe_stage_skid: RTL and testbench

//  Generic, parametrised pipeline stage register. It supersedes the fixed-field
//  IF/ID, ID/EX and EX/MEM latches that use zero/stall inputs.

---
 rtl/pipe_stage_skid.sv | 147 ++++++++++++++
 tb/tb_pipe_stage_skid.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline stage with a valid/ready handshake and a two-entry skid buffer (head M, skid S).
// in_ready comes only from registered state and flush, so backpressure never forms a combinational path.
module pipe_stage_skid #(
    parameter int PC_BITS        = 32,
    parameter int DATA_BITS      = 128,
    parameter int CNT_BITS       = 16,
    parameter bit ZERO_ON_BUBBLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_BITS-1:0]   in_pc,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_BITS-1:0]   out_pc,
    output logic [DATA_BITS-1:0] out_data,
    output logic [1:0]           occupancy,
    output logic [CNT_BITS-1:0]  drop_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [PC_BITS-1:0]    r_m_pc;
    logic [PC_BITS-1:0]    r_s_pc;
    logic [DATA_BITS-1:0]  r_m_data;
    logic [DATA_BITS-1:0]  r_s_data;
    logic [CNT_BITS-1:0]   r_drop_count;

    logic                  w_accept;
    logic                  w_emit;
    logic                  w_load_m_in;
    logic                  w_load_m_s;
    logic                  w_load_s_in;
    logic [CNT_BITS:0]     w_drop_sum;

    assign w_accept = in_valid & in_ready;
    assign w_emit   = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load_m_in  = 1'b0;
        w_load_m_s   = 1'b0;
        w_load_s_in  = 1'b0;
        if (flush) begin
            w_state_next = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = ST_ONE;
                        w_load_m_in  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_emit) begin
                        w_load_m_in  = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = ST_TWO;
                        w_load_s_in  = 1'b1;
                    end else if (w_emit) begin
                        w_state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // S is always the younger entry, so it moves up to the head
                    if (w_emit) begin
                        w_state_next = ST_ONE;
                        w_load_m_s   = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state != ST_TWO) && !flush;
        out_valid = (r_state != ST_EMPTY);
        occupancy = r_state;
        out_pc    = r_m_pc;
        out_data  = r_m_data;
        if (ZERO_ON_BUBBLE && (r_state == ST_EMPTY)) begin
            out_pc   = '0;
            out_data = '0;
        end
    end

    // Registers load only on an accepted entry, so payload seen while in_valid=0 is never captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_pc   <= '0;
            r_m_data <= '0;
            r_s_pc   <= '0;
            r_s_data <= '0;
        end else if (flush) begin
            r_m_pc   <= '0;
            r_m_data <= '0;
            r_s_pc   <= '0;
            r_s_data <= '0;
        end else begin
            if (w_load_m_in) begin
                r_m_pc   <= in_pc;
                r_m_data <= in_data;
            end else if (w_load_m_s) begin
                r_m_pc   <= r_s_pc;
                r_m_data <= r_s_data;
            end
            if (w_load_s_in) begin
                r_s_pc   <= in_pc;
                r_s_data <= in_data;
            end
        end
    end

    // One spare bit catches overflow; the counter then sticks at all-ones
    assign w_drop_sum = {1'b0, r_drop_count} + {{(CNT_BITS-1){1'b0}}, occupancy};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
        end else if (flush) begin
            r_drop_count <= w_drop_sum[CNT_BITS] ? {CNT_BITS{1'b1}} : w_drop_sum[CNT_BITS-1:0];
        end
    end

    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed stimulus plus a random phase; a negedge monitor
// keeps a FIFO scoreboard of accepted entries and compares every presented head.
module tb_pipe_stage_skid;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [31:0]  in_pc = '0;
    logic [127:0] in_data = '0;

    logic         in_ready;
    logic         out_valid;
    logic [31:0]  out_pc;
    logic [127:0] out_data;
    logic [1:0]   occupancy;
    logic [15:0]  drop_count;

    logic         sat_in_ready;
    logic         sat_out_valid;
    logic [31:0]  sat_out_pc;
    logic [127:0] sat_out_data;
    logic [1:0]   sat_occupancy;
    logic [1:0]   sat_drop_count;

    typedef struct {
        logic [31:0]  pc;
        logic [127:0] data;
    } ent_t;

    ent_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   drop_exp = 0;
    int   drop_sat_exp = 0;
    int   m_occ;
    logic m_ready;

    always #5 clk = ~clk;

    pipe_stage_skid #(.PC_BITS(32), .DATA_BITS(128), .CNT_BITS(16), .ZERO_ON_BUBBLE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
        .occupancy(occupancy), .drop_count(drop_count)
    );

    pipe_stage_skid #(.PC_BITS(32), .DATA_BITS(128), .CNT_BITS(2), .ZERO_ON_BUBBLE(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_pc(in_pc), .in_data(in_data),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_pc(sat_out_pc), .out_data(sat_out_data),
        .occupancy(sat_occupancy), .drop_count(sat_drop_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk_data(input logic [31:0] pc);
        return {pc, ~pc, pc ^ 32'hDEAD_BEEF, pc + 32'h0BAD_F00D};
    endfunction

    task automatic cyc(input logic v, input logic [31:0] pc, input logic [127:0] d,
                       input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_pc     = pc;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 32'h0, 128'h0, ordy, 1'b0);
    endtask

    // Scoreboard monitor: inputs are stable at the negedge, state reflects the last posedge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            drop_exp     = 0;
            drop_sat_exp = 0;
        end else begin
            m_occ   = exp_q.size();
            m_ready = (m_occ < 2) && !flush;
            check("in_ready", 128'(in_ready), 128'(m_ready));
            check("occupancy", 128'(occupancy), 128'(m_occ));
            check("out_valid", 128'(out_valid), 128'(m_occ != 0));
            check("drop_count", 128'(drop_count), 128'(drop_exp));
            check("drop_count_sat", 128'(sat_drop_count), 128'(drop_sat_exp));
            if (m_occ == 0) begin
                check("bubble_pc", 128'(out_pc), 128'h0);
                check("bubble_data", out_data, 128'h0);
            end else begin
                check("head_pc", 128'(out_pc), 128'(exp_q[0].pc));
                check("head_data", out_data, exp_q[0].data);
            end
            if (flush) begin
                drop_exp     = (drop_exp + m_occ > 65535) ? 65535 : drop_exp + m_occ;
                drop_sat_exp = (drop_sat_exp + m_occ > 3) ? 3 : drop_sat_exp + m_occ;
                exp_q.delete();
            end else begin
                if (m_occ != 0 && out_ready) begin
                    $display("emit pc=%08h data=%032h", exp_q[0].pc, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
                if (in_valid && m_ready) begin
                    exp_q.push_back('{pc: in_pc, data: in_data});
                end
            end
        end
    end

    logic [1:0] sat_seq [4];
    logic [31:0] rpc;

    initial begin
        sat_seq[0] = 2'd1;
        sat_seq[1] = 2'd2;
        sat_seq[2] = 2'd3;
        sat_seq[3] = 2'd3;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'h0);
        check("rst_occupancy", 128'(occupancy), 128'h0);
        check("rst_drop", 128'(drop_count), 128'h0);
        check("rst_out_pc", 128'(out_pc), 128'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: streaming at full rate
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 32'h100 + 32'(4 * i), mk_data(32'h100 + 32'(4 * i)), 1'b1, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);

        // 2: backpressure fills both slots
        cyc(1'b1, 32'h200, mk_data(32'h200), 1'b0, 1'b0);
        cyc(1'b1, 32'h204, mk_data(32'h204), 1'b0, 1'b0);
        cyc(1'b1, 32'h208, mk_data(32'h208), 1'b0, 1'b0);
        @(negedge clk);
        check("bp_occupancy", 128'(occupancy), 128'h2);
        check("bp_in_ready", 128'(in_ready), 128'h0);
        check("bp_out_pc", 128'(out_pc), 128'h200);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // 3: flush while full, concurrent input must be refused
        cyc(1'b1, 32'h300, mk_data(32'h300), 1'b0, 1'b0);
        cyc(1'b1, 32'h304, mk_data(32'h304), 1'b0, 1'b0);
        cyc(1'b1, 32'h308, mk_data(32'h308), 1'b0, 1'b1);
        idle(1'b1);
        @(negedge clk);
        check("flush_occupancy", 128'(occupancy), 128'h0);
        check("flush_out_valid", 128'(out_valid), 128'h0);
        check("flush_out_pc", 128'(out_pc), 128'h0);
        check("flush_drop", 128'(drop_count), 128'h2);
        idle(1'b1);

        // 4: narrow counter saturates
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 32'h400 + 32'(4 * k), mk_data(32'h400 + 32'(4 * k)), 1'b0, 1'b0);
            cyc(1'b0, 32'h0, 128'h0, 1'b0, 1'b1);
            idle(1'b0);
            @(negedge clk);
            check("sat_drop", 128'(sat_drop_count), 128'(sat_seq[k]));
            check("wide_drop", 128'(drop_count), 128'(k + 1));
        end

        // 5: asynchronous reset while full
        cyc(1'b1, 32'h500, mk_data(32'h500), 1'b0, 1'b0);
        cyc(1'b1, 32'h504, mk_data(32'h504), 1'b0, 1'b0);
        idle(1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'h0);
        check("arst_out_pc", 128'(out_pc), 128'h0);
        check("arst_out_data", out_data, 128'h0);
        check("arst_occupancy", 128'(occupancy), 128'h0);
        check("arst_drop", 128'(drop_count), 128'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 128'(in_ready), 128'h1);
        check("post_rst_drop", 128'(drop_count), 128'h0);

        // 6: random traffic; garbage payload while in_valid=0 must never be captured
        rpc = 32'h1000;
        for (int c = 0; c < 10000; c++) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            cyc(v, v ? rpc : $urandom, {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            if (v) rpc = rpc + 32'h4;
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        check("drain_out_valid", 128'(out_valid), 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
